// File: rtl/fc_16_argmax.sv
// fc_16_argmax: captures a packed vector of N signed scores and scans it one
// score per cycle, reporting the index and value of the largest score.
// Ties keep the lowest index because a score only wins when strictly greater.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start_flag; the only state that loads the buffer
// SCAN  | one signed compare per cycle, scores 1 .. N-1
// DONE  | publish best index/value, pulse end_flag, return to IDLE
module fc_16_argmax #(
    parameter int N  = 16,
    parameter int W  = 10,
    parameter int IW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_start_flag,
    input  logic [N*W-1:0] i_in,
    output logic [IW-1:0]  o_out_index,
    output logic [W-1:0]   o_out_value,
    output logic           o_end_flag,
    output logic           o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [N*W-1:0]  r_buf;
    logic [W-1:0]    r_best_val;
    logic [IW-1:0]   r_best_idx;
    logic [IW-1:0]   r_cnt;

    logic [W-1:0]    w_scores [N];
    logic [W-1:0]    w_cur;
    logic            w_better;
    logic            w_last;
    logic            w_load;
    logic            w_step;
    logic            w_finish;

    // Score k sits at the top of the packed vector for k = 0.
    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign w_scores[g] = r_buf[(N-1-g)*W +: W];
    end

    assign w_cur    = w_scores[r_cnt];
    assign w_better = $signed(w_cur) > $signed(r_best_val);
    assign w_last   = (r_cnt == IW'(N-1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        o_busy   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start_flag) begin
                    w_load = 1'b1;
                    w_next = S_SCAN;
                end
            end
            S_SCAN: begin
                o_busy = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                o_busy   = 1'b1;
                w_finish = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Capture buffer, running best and scan counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf      <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
            r_cnt      <= '0;
        end else if (w_load) begin
            r_buf      <= i_in;
            r_best_val <= i_in[N*W-1 -: W];
            r_best_idx <= '0;
            r_cnt      <= IW'(1);
        end else if (w_step) begin
            if (w_better) begin
                r_best_val <= w_cur;
                r_best_idx <= r_cnt;
            end
            r_cnt <= r_cnt + IW'(1);
        end
    end

    // Result registers hold until the next DONE; end_flag is a single pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_out_index <= '0;
            o_out_value <= '0;
            o_end_flag  <= 1'b0;
        end else begin
            o_end_flag <= w_finish;
            if (w_finish) begin
                o_out_index <= r_best_idx;
                o_out_value <= r_best_val;
            end
        end
    end

endmodule

// File: tb/tb_fc_16_argmax.sv
// Bench for fc_16_argmax: directed vectors, an argmax/timing model and a
// per-cycle compare process, plus literal expectations per vector.
module tb_fc_16_argmax;

    logic         clk;
    logic         reset;
    logic         i_start_flag;
    logic [159:0] i_in;
    logic [3:0]   o_out_index;
    logic [9:0]   o_out_value;
    logic         o_end_flag;
    logic         o_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_dut_end = 0;

    logic [9:0] sc [16];

    fc_16_argmax #(.N(16), .W(10), .IW(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start_flag (i_start_flag),
        .i_in         (i_in),
        .o_out_index  (o_out_index),
        .o_out_value  (o_out_value),
        .o_end_flag   (o_end_flag),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [159:0] pack_sc();
        logic [159:0] v;
        for (int k = 0; k < 16; k++) v[159-10*k -: 10] = sc[k];
        return v;
    endfunction

    // Plain argmax over signed scores: first occurrence of the maximum.
    function automatic logic [13:0] argmax(input logic [159:0] v);
        int best_v;
        int best_i;
        logic signed [9:0] t;
        t = v[159:150];
        best_v = t;
        best_i = 0;
        for (int k = 1; k < 16; k++) begin
            t = v[159-10*k -: 10];
            if (int'(t) > best_v) begin
                best_v = t;
                best_i = k;
            end
        end
        return {4'(best_i), 10'(best_v)};
    endfunction

    // Model: a start accepted when idle yields a result 16 edges later.
    int         rem = 0;
    logic       en = 1'b0;
    logic       e_end = 1'b0;
    logic [3:0] e_idx = '0;
    logic [9:0] e_val = '0;
    logic [13:0] pend = '0;

    always @(posedge clk) begin
        if (reset) begin
            rem   <= 0;
            e_end <= 1'b0;
            e_idx <= '0;
            e_val <= '0;
            en    <= 1'b1;
        end else begin
            e_end <= 1'b0;
            if (rem == 0) begin
                if (i_start_flag) begin
                    rem  <= 16;
                    pend <= argmax(i_in);
                end
            end else begin
                rem <= rem - 1;
                if (rem == 1) begin
                    e_end <= 1'b1;
                    e_idx <= pend[13:10];
                    e_val <= pend[9:0];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("end_flag", int'(o_end_flag), int'(e_end));
            chk("busy", int'(o_busy), int'(rem != 0));
            chk("out_index", int'(o_out_index), int'(e_idx));
            chk("out_value", int'(o_out_value), int'(e_val));
            if (o_end_flag) n_dut_end++;
        end
    end

    // Caller sits at a negedge; the next posedge samples the start.
    task automatic do_start(input logic [159:0] v, output int t);
        i_start_flag = 1'b1;
        i_in = v;
        @(negedge clk);
        i_start_flag = 1'b0;
        i_in = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        t = cyc;
    endtask

    task automatic wait_end(output int t);
        bit found = 1'b0;
        t = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (o_end_flag) begin
                found = 1'b1;
                t = cyc;
            end
        end
        if (!found) chk("end_timeout", 0, 1);
    endtask

    task automatic run_case(input string nm, input int exp_idx, input int exp_val);
        int ts;
        int te;
        do_start(pack_sc(), ts);
        wait_end(te);
        chk({nm, "_latency"}, te - ts, 16);
        chk({nm, "_index"}, int'(o_out_index), exp_idx);
        chk({nm, "_value"}, int'(o_out_value), exp_val);
        @(negedge clk);
        chk({nm, "_busy_after"}, int'(o_busy), 0);
    endtask

    initial begin
        int ts;
        int te;
        logic [159:0] va;
        logic [159:0] vb;

        reset = 1'b1;
        i_start_flag = 1'b0;
        i_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_index", int'(o_out_index), 0);
        chk("rst_value", int'(o_out_value), 0);
        chk("rst_end", int'(o_end_flag), 0);
        chk("rst_busy", int'(o_busy), 0);
        reset = 1'b0;
        @(negedge clk);

        foreach (sc[k]) sc[k] = 10'h005;
        run_case("all_equal", 0, 10'h005);

        foreach (sc[k]) sc[k] = 10'h000;
        sc[15] = 10'h1FF;
        run_case("last_wins", 15, 10'h1FF);

        foreach (sc[k]) sc[k] = 10'h3FD;
        sc[7] = 10'h3FF;
        run_case("signed_a", 7, 10'h3FF);

        foreach (sc[k]) sc[k] = 10'h3F0;
        sc[0] = 10'h200;
        sc[3] = 10'h001;
        run_case("signed_b", 3, 10'h001);

        foreach (sc[k]) sc[k] = 10'd50;
        sc[4] = 10'd100;
        sc[9] = 10'd100;
        run_case("tie", 4, 100);

        // Start while busy: second start at T+5 dropped, retried at T+17.
        foreach (sc[k]) sc[k] = 10'd0;
        sc[2] = 10'd50;
        va = pack_sc();
        sc[2] = 10'd0;
        sc[11] = 10'd60;
        vb = pack_sc();
        do_start(va, ts);
        repeat (4) @(negedge clk);
        i_start_flag = 1'b1;
        i_in = vb;
        @(negedge clk);
        i_start_flag = 1'b0;
        i_in = '0;
        wait_end(te);
        chk("busy_start_time", te - ts, 16);
        chk("busy_start_index", int'(o_out_index), 2);
        do_start(vb, te);
        chk("retry_accept_busy", int'(o_busy), 1);
        wait_end(te);
        chk("retry_time", te - ts, 33);
        chk("retry_index", int'(o_out_index), 11);
        chk("retry_value", int'(o_out_value), 60);

        // Reset at T+8 aborts the scan; fresh start at T+10.
        do_start(va, ts);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", int'(o_busy), 0);
        chk("abort_index", int'(o_out_index), 0);
        chk("abort_value", int'(o_out_value), 0);
        chk("abort_end", int'(o_end_flag), 0);
        @(negedge clk);
        do_start(vb, te);
        chk("fresh_start_time", te - ts, 10);
        wait_end(te);
        chk("fresh_end_time", te - ts, 26);
        chk("fresh_index", int'(o_out_index), 11);

        // Reset wins over a coincident start.
        @(negedge clk);
        reset = 1'b1;
        i_start_flag = 1'b1;
        i_in = va;
        @(negedge clk);
        reset = 1'b0;
        i_start_flag = 1'b0;
        chk("rst_prio_busy", int'(o_busy), 0);
        repeat (20) @(negedge clk);
        chk("rst_prio_busy_late", int'(o_busy), 0);

        chk("end_count", n_dut_end, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fc_16_argmax.md
# fc_16_argmax

Classification stage placed directly after the 64→16 fully-connected layer. It captures the layer's 16 packed 10-bit scores when that layer's `end_flag` pulses. It then scans the scores sequentially, one per cycle, and reports the index and value of the largest score with a one-cycle `end_flag` pulse. The block is the consumer end of the FC layer's `out`/`end_flag` interface and feeds the top-level result register.

## Interface
- `N`, 16, number of scores in the input vector.
- `W`, 10, width of each score in bits (signed two's complement).
- `IW`, 4, width of the index output (must satisfy 2^IW ≥ N).

- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_flag`  in  1  one-cycle pulse marking `in` valid; driven by the FC layer's `end_flag`.
- `in`  in  N*W (160)  packed scores; score k is at bits [(N-k)*W-1 : (N-k-1)*W], so score 0 occupies [159:150].
- `out_index`  out  IW  index of the winning score.
- `out_value`  out  W  value of the winning score.
- `end_flag`  out  1  one-cycle pulse: `out_index`/`out_value` are updated and valid.
- `busy`  out  1  high while a scan is in progress; `start_flag` is ignored while `busy` is high.

## Operation
- State machine with states IDLE, SCAN and DONE. Reset state is IDLE.
- **IDLE**, `start_flag`=1 at an edge:
  - Capture `in` into an internal N*W buffer.
  - Set best value = score 0, best index = 0, counter = 1.
  - Go to SCAN and set `busy`=1.
- **SCAN**, each edge:
  - Compare buffered score[counter] against best using a **signed** comparison.
  - Replace best only if score[counter] > best (strictly greater). Ties therefore keep the lowest index.
  - Increment the counter.
  - When the score just compared is score N-1, go to DONE.
- **DONE**, one edge:
  - `out_index` ← best index, `out_value` ← best value.
  - `end_flag` ← 1, `busy` ← 0, go to IDLE.
- `end_flag` is 0 on every other edge.
- `out_index`/`out_value` hold their last result until the next DONE.
- `start_flag` in SCAN or DONE is dropped. It is not queued and does not disturb the buffer or the scan in progress.
- The input buffer is loaded only in IDLE on `start_flag`. `in` may change freely after the capture edge.
- No arithmetic beyond the comparison and the counter. No saturation or width growth; `out_value` is the buffered score bit-for-bit.

## Timing
- Reset values: `out_index`=0, `out_value`=0, `end_flag`=0, `busy`=0, state IDLE, counter 0, buffer 0.
- Reset has priority over `start_flag` on the same edge.
- Reset during SCAN or DONE aborts the scan immediately:
  - No `end_flag` is produced.
  - Outputs return to their reset values.
- Latency for a start sampled at edge T:
  - SCAN occupies edges T+1 … T+N-1 (15 comparisons).
  - DONE occurs at edge T+N (T+16).
  - `end_flag` is high for the single cycle between edges T+16 and T+17.
- `busy` is high from after edge T to after edge T+16.
- The earliest next accepted `start_flag` is at edge T+17. Minimum start-to-start period is N+1 = 17 cycles.
- The upstream FC layer's result period is far longer than 17 cycles, so in normal operation no start is dropped.
- One `end_flag` pulse per accepted start, never more.

## Test plan
- **All equal:** `in` = sixteen copies of 10'h005, start at T → `end_flag` exactly one cycle after edge T+16, `out_index`=0, `out_value`=10'h005, `busy` low afterwards.
- **Last wins:** score 15 = 10'h1FF (+511), all others 0 → `out_index`=15, `out_value`=10'h1FF.
- **Signed compare:** all scores 10'h3FD (−3) except score 7 = 10'h3FF (−1); also test score 0 = 10'h200 (−512) with score 3 = 10'h001 → first case gives index 7 / 10'h3FF, second case gives index 3 / 10'h001.
- **Tie:** scores 4 and 9 = 100, all others 50 → `out_index`=4, `out_value`=100.
- **Start while busy:** first start at T (max at index 2), second start with different data (max at index 11) at edge T+5 → a single `end_flag` at T+16 with index 2. A start at T+17 is accepted and yields index 11 at T+33.
- **Reset mid-scan:** start at T, `reset` at edge T+8 → `busy`=0, `end_flag` is never asserted, outputs are 0. A fresh start at T+10 completes normally with `end_flag` after edge T+26.
